position_obj_ctl: RTL and testbench

Two-axis, parametrised position controller for a sprite or object: the player ship, enemies or bullets. It converts held direction buttons into rate-limited position steps on X and Y, clamped to a configurable play window. It adds an enable/freeze input, a synchronous position load (respawn or teleport), a moving flag and edge-contact flags. It sits between the keyboard/button decoder and the draw_rect stage, and supplies xpos/ypos to the renderer.

---
 rtl/position_obj_ctl.sv | 212 +++++++++++++++++++++
 tb/tb_position_obj_ctl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/position_obj_ctl.sv
// ---------------------------------------------------------------------------
// position_obj_ctl
//
// Two-axis position controller for a sprite/object (ship, enemy, bullet).
// Held direction buttons drive an independent IDLE/NEG/POS state machine per
// axis; a shared prescaler turns "axis active" into rate-limited steps of
// STEP pixels, and each step is clamped to the [MIN, MAX] play window.
// A one-cycle load strobe teleports the object (clamped) and an enable input
// freezes motion.
//
// Ports:
//   pclk      in   1      pixel clock, all state changes on rising edge
//   rst       in   1      asynchronous active-high reset
//   en        in   1      1 = motion allowed, 0 = freeze
//   left      in   1      move toward X_MIN
//   right     in   1      move toward X_MAX
//   up        in   1      move toward Y_MIN
//   down      in   1      move toward Y_MAX
//   load      in   1      one-cycle strobe, load load_x/load_y (clamped)
//   load_x    in   POS_W  X value to load
//   load_y    in   POS_W  Y value to load
//   xpos_out  out  POS_W  registered X position
//   ypos_out  out  POS_W  registered Y position
//   moving    out  1      registered, 1 while either axis is not IDLE
//   at_edge   out  4      {y==Y_MAX, y==Y_MIN, x==X_MAX, x==X_MIN}
// ---------------------------------------------------------------------------
module position_obj_ctl #(
    parameter int POS_W      = 12,
    parameter int CNT_W      = 21,
    parameter int TICK_LIMIT = 30000,
    parameter int STEP       = 1,
    parameter int X_MIN      = 80,
    parameter int X_MAX      = 896,
    parameter int Y_MIN      = 0,
    parameter int Y_MAX      = 704,
    parameter int X_INIT     = 512,
    parameter int Y_INIT     = 640
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             en,
    input  logic             left,
    input  logic             right,
    input  logic             up,
    input  logic             down,
    input  logic             load,
    input  logic [POS_W-1:0] load_x,
    input  logic [POS_W-1:0] load_y,
    output logic [POS_W-1:0] xpos_out,
    output logic [POS_W-1:0] ypos_out,
    output logic             moving,
    output logic [3:0]       at_edge
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NEG  = 2'd1,
        POS  = 2'd2
    } axis_state_t;

    localparam logic [POS_W-1:0] X_MIN_N  = POS_W'(X_MIN);
    localparam logic [POS_W-1:0] X_MAX_N  = POS_W'(X_MAX);
    localparam logic [POS_W-1:0] Y_MIN_N  = POS_W'(Y_MIN);
    localparam logic [POS_W-1:0] Y_MAX_N  = POS_W'(Y_MAX);
    localparam logic [POS_W-1:0] X_INIT_N = POS_W'(X_INIT);
    localparam logic [POS_W-1:0] Y_INIT_N = POS_W'(Y_INIT);
    localparam logic [POS_W-1:0] STEP_N   = POS_W'(STEP);
    localparam logic [CNT_W-1:0] TICK_N   = CNT_W'(TICK_LIMIT);

    axis_state_t      x_state;
    axis_state_t      y_state;
    axis_state_t      x_next;
    axis_state_t      y_next;
    logic [CNT_W-1:0] counter;
    logic             tick;

    // Per-axis transition table. Pressing both directions counts as no
    // input, and any change of direction drops back to IDLE first, so a
    // reversal always costs one idle cycle.
    function automatic axis_state_t axis_next(input axis_state_t cur,
                                              input logic neg,
                                              input logic pos);
        axis_state_t nxt;
        nxt = IDLE;
        case (cur)
            IDLE: begin
                if (neg && !pos) begin
                    nxt = NEG;
                end else if (pos && !neg) begin
                    nxt = POS;
                end
            end
            NEG: begin
                if (neg && !pos) begin
                    nxt = NEG;
                end
            end
            POS: begin
                if (pos && !neg) begin
                    nxt = POS;
                end
            end
            default: nxt = IDLE;
        endcase
        return nxt;
    endfunction

    // One step along an axis. The bound tests are done one bit wider than
    // the position so that cur-STEP cannot wrap below zero and cur+STEP
    // cannot wrap past the top of the range; the subtraction/addition itself
    // only happens once the result is known to lie inside the window.
    function automatic logic [POS_W-1:0] step_axis(input axis_state_t st,
                                                   input logic [POS_W-1:0] cur,
                                                   input logic [POS_W-1:0] lo,
                                                   input logic [POS_W-1:0] hi);
        logic [POS_W-1:0] res;
        res = cur;
        case (st)
            NEG: begin
                if ({1'b0, cur} < ({1'b0, lo} + {1'b0, STEP_N})) begin
                    res = lo;
                end else begin
                    res = cur - STEP_N;
                end
            end
            POS: begin
                if (({1'b0, cur} + {1'b0, STEP_N}) > {1'b0, hi}) begin
                    res = hi;
                end else begin
                    res = cur + STEP_N;
                end
            end
            default: res = cur;
        endcase
        return res;
    endfunction

    // Loaded positions are forced into the play window so that a respawn
    // or teleport can never park the object outside the clamp bounds.
    function automatic logic [POS_W-1:0] clamp(input logic [POS_W-1:0] v,
                                               input logic [POS_W-1:0] lo,
                                               input logic [POS_W-1:0] hi);
        logic [POS_W-1:0] res;
        res = v;
        if (v < lo) begin
            res = lo;
        end else if (v > hi) begin
            res = hi;
        end
        return res;
    endfunction

    // Next-state decode for both axes. A load or a freeze overrides the
    // buttons and parks both axes in IDLE; held buttons re-engage on the
    // edge after the override goes away.
    always_comb begin
        x_next = IDLE;
        y_next = IDLE;
        if (!load && en) begin
            x_next = axis_next(x_state, left, right);
            y_next = axis_next(y_state, up, down);
        end
    end

    // The shared prescaler fires when it reaches its terminal count while
    // at least one axis is active. It is not restarted when a second axis
    // joins, so the late axis simply rides the existing tick cadence.
    always_comb begin
        tick = en && !load && ((x_state != IDLE) || (y_state != IDLE))
               && (counter == TICK_N);
    end

    // All registered state: axis FSMs, prescaler, positions and the moving
    // flag. moving is computed from the next states so it lines up with the
    // state registers rather than lagging them by a cycle. Load has priority
    // over everything except reset.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            x_state  <= IDLE;
            y_state  <= IDLE;
            counter  <= '0;
            moving   <= 1'b0;
            xpos_out <= X_INIT_N;
            ypos_out <= Y_INIT_N;
        end else begin
            x_state <= x_next;
            y_state <= y_next;
            moving  <= (x_next != IDLE) || (y_next != IDLE);

            if (load || !en || ((x_state == IDLE) && (y_state == IDLE)) || tick) begin
                counter <= '0;
            end else begin
                counter <= counter + 1'b1;
            end

            if (load) begin
                xpos_out <= clamp(load_x, X_MIN_N, X_MAX_N);
                ypos_out <= clamp(load_y, Y_MIN_N, Y_MAX_N);
            end else if (tick) begin
                xpos_out <= step_axis(x_state, xpos_out, X_MIN_N, X_MAX_N);
                ypos_out <= step_axis(y_state, ypos_out, Y_MIN_N, Y_MAX_N);
            end
        end
    end

    // Edge-contact flags are decoded straight from the registered positions.
    always_comb begin
        at_edge = {ypos_out == Y_MAX_N, ypos_out == Y_MIN_N,
                   xpos_out == X_MAX_N, xpos_out == X_MIN_N};
    end

endmodule

// File: tb/tb_position_obj_ctl.sv
// ---------------------------------------------------------------------------
// tb_position_obj_ctl
//
// Self-checking bench for position_obj_ctl. Two instances share the same
// stimulus: dut1 (TICK_LIMIT=3, STEP=1) and dut4 (TICK_LIMIT=3, STEP=4).
// Each test fills a table of per-cycle records {inputs, expected outputs};
// applying a record pushes it onto a scoreboard queue and the record is
// popped and compared one cycle later, just after the clock edge.
// ---------------------------------------------------------------------------
module tb_position_obj_ctl;

    localparam int POS_W = 12;
    localparam int TL    = 3;

    localparam bit H = 1'b1;
    localparam bit L = 1'b0;

    logic             pclk = 1'b0;
    logic             rst  = 1'b1;
    logic             en   = 1'b1;
    logic             left = 1'b0;
    logic             right = 1'b0;
    logic             up   = 1'b0;
    logic             down = 1'b0;
    logic             load = 1'b0;
    logic [POS_W-1:0] load_x = '0;
    logic [POS_W-1:0] load_y = '0;

    logic [POS_W-1:0] x1;
    logic [POS_W-1:0] y1;
    logic             mov1;
    logic [3:0]       edge1;
    logic [POS_W-1:0] x4;
    logic [POS_W-1:0] y4;
    logic             mov4;
    logic [3:0]       edge4;

    typedef struct {
        int tid;
        bit en;
        bit l;
        bit r;
        bit u;
        bit d;
        bit ld;
        int lx;
        int ly;
        int ex;
        int ey;
        bit emov;
        bit sel4;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    int total = 0;
    int bad   = 0;

    position_obj_ctl #(.POS_W(POS_W), .CNT_W(21), .TICK_LIMIT(TL), .STEP(1))
    dut1 (
        .pclk(pclk), .rst(rst), .en(en),
        .left(left), .right(right), .up(up), .down(down),
        .load(load), .load_x(load_x), .load_y(load_y),
        .xpos_out(x1), .ypos_out(y1), .moving(mov1), .at_edge(edge1)
    );

    position_obj_ctl #(.POS_W(POS_W), .CNT_W(21), .TICK_LIMIT(TL), .STEP(4))
    dut4 (
        .pclk(pclk), .rst(rst), .en(en),
        .left(left), .right(right), .up(up), .down(down),
        .load(load), .load_x(load_x), .load_y(load_y),
        .xpos_out(x4), .ypos_out(y4), .moving(mov4), .at_edge(edge4)
    );

    // Free-running pixel clock, rising edges at 5, 15, 25, ...
    initial begin
        forever #5 pclk = ~pclk;
    end

    // Guard against a run that never reaches its summary.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Window constants of the default play area, used for edge expectations.
    function automatic int expEdge(input int x, input int y);
        logic [3:0] e;
        e = {y == 704, y == 0, x == 896, x == 80};
        return int'(e);
    endfunction

    task automatic check(input int tid, input string name,
                         input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL t%0d %s actual=%0d required=%0d",
                     tid, name, act, exp);
        end
    endtask

    task automatic addVec(input int tid, input bit en_i,
                          input bit l, input bit r, input bit u, input bit d,
                          input bit ld, input int lx, input int ly,
                          input int ex, input int ey,
                          input bit mov, input bit s4);
        vec_t v;
        v.tid = tid;  v.en = en_i;
        v.l = l;      v.r = r;    v.u = u;   v.d = d;
        v.ld = ld;    v.lx = lx;  v.ly = ly;
        v.ex = ex;    v.ey = ey;  v.emov = mov;
        v.sel4 = s4;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        en     = v.en;
        left   = v.l;
        right  = v.r;
        up     = v.u;
        down   = v.d;
        load   = v.ld;
        load_x = POS_W'(v.lx);
        load_y = POS_W'(v.ly);
        sb.push_back(v);
    endtask

    task automatic checkOutput();
        vec_t v;
        if (sb.size() == 0) begin
            check(-1, "scoreboard_empty", 0, 1);
            return;
        end
        v = sb.pop_front();
        if (v.sel4) begin
            check(v.tid, "dut4_x",      int'(x4),    v.ex);
            check(v.tid, "dut4_y",      int'(y4),    v.ey);
            check(v.tid, "dut4_moving", int'(mov4),  int'(v.emov));
            check(v.tid, "dut4_at_edge", int'(edge4), expEdge(v.ex, v.ey));
        end else begin
            check(v.tid, "dut1_x",      int'(x1),    v.ex);
            check(v.tid, "dut1_y",      int'(y1),    v.ey);
            check(v.tid, "dut1_moving", int'(mov1),  int'(v.emov));
            check(v.tid, "dut1_at_edge", int'(edge1), expEdge(v.ex, v.ey));
        end
    endtask

    task automatic runVecs();
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(posedge pclk);
            #1;
            checkOutput();
        end
        vecs.delete();
    endtask

    task automatic checkInit(input int tid);
        check(tid, "init_x1",    int'(x1),    512);
        check(tid, "init_y1",    int'(y1),    640);
        check(tid, "init_mov1",  int'(mov1),  0);
        check(tid, "init_edge1", int'(edge1), 0);
        check(tid, "init_x4",    int'(x4),    512);
        check(tid, "init_mov4",  int'(mov4),  0);
    endtask

    task automatic doReset(input int tid);
        rst   = 1'b1;
        en    = 1'b1;
        left  = 1'b0;
        right = 1'b0;
        up    = 1'b0;
        down  = 1'b0;
        load  = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        rst = 1'b0;
        checkInit(tid);
    endtask

    initial begin
        $display("[TB] start");

        // Test 1: hold right, first step 4 cycles after the FSM engages.
        doReset(1);
        for (int n = 1; n <= 13; n++) begin
            addVec(1, H, L, H, L, L, L, 0, 0,
                   512 + (n >= 5 ? 1 : 0) + (n >= 9 ? 1 : 0) + (n >= 13 ? 1 : 0),
                   640, H, L);
        end
        for (int n = 1; n <= 2; n++) begin
            addVec(1, H, L, L, L, L, L, 0, 0, 515, 640, L, L);
        end
        runVecs();

        // Test 2: opposite buttons together mean no motion at all.
        doReset(2);
        for (int n = 1; n <= 20; n++) begin
            addVec(2, H, H, H, L, L, L, 0, 0, 512, 640, L, L);
        end
        runVecs();

        // Test 3: STEP=4 near X_MIN clamps at 80 instead of going to 78.
        doReset(3);
        addVec(3, H, L, L, L, L, H, 82, 640, 82, 640, L, H);
        for (int n = 1; n <= 9; n++) begin
            addVec(3, H, H, L, L, L, L, 0, 0, (n >= 5) ? 80 : 82, 640, H, H);
        end
        runVecs();

        // Test 4: diagonal, then down released; x keeps the shared cadence.
        doReset(4);
        for (int n = 1; n <= 9; n++) begin
            addVec(4, H, L, H, L, (n <= 5) ? H : L, L, 0, 0,
                   512 + (n >= 5 ? 1 : 0) + (n >= 9 ? 1 : 0),
                   (n >= 5) ? 641 : 640, H, L);
        end
        runVecs();

        // Test 4b: down joins late and steps on the existing shared tick.
        doReset(41);
        for (int n = 1; n <= 5; n++) begin
            addVec(41, H, L, H, L, (n >= 3) ? H : L, L, 0, 0,
                   (n >= 5) ? 513 : 512, (n >= 5) ? 641 : 640, H, L);
        end
        runVecs();

        // Test 5: freeze, load while frozen, stick at X_MAX, load priority.
        doReset(5);
        for (int n = 1; n <= 6; n++) begin
            addVec(5, H, L, H, L, L, L, 0, 0, (n >= 5) ? 513 : 512, 640, H, L);
        end
        for (int n = 7; n <= 10; n++) begin
            addVec(5, L, L, H, L, L, L, 0, 0, 513, 640, L, L);
        end
        addVec(5, L, L, H, L, L, H, 1000, 10, 896, 10, L, L);
        for (int n = 1; n <= 2; n++) begin
            addVec(5, L, L, H, L, L, L, 0, 0, 896, 10, L, L);
        end
        for (int n = 1; n <= 6; n++) begin
            addVec(5, H, L, H, L, L, L, 0, 0, 896, 10, H, L);
        end
        addVec(5, H, L, H, L, L, H, 50, 2000, 80, 704, L, L);
        for (int n = 1; n <= 5; n++) begin
            addVec(5, H, L, H, L, L, L, 0, 0, (n >= 5) ? 81 : 80, 704, H, L);
        end
        runVecs();

        // Test 6: asynchronous reset between edges while moving.
        doReset(6);
        for (int n = 1; n <= 6; n++) begin
            addVec(6, H, L, H, L, L, L, 0, 0, (n >= 5) ? 513 : 512, 640, H, L);
        end
        runVecs();
        #3;
        rst = 1'b1;
        #1;
        checkInit(6);
        @(posedge pclk);
        #1;
        rst = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            addVec(6, H, L, H, L, L, L, 0, 0, (n >= 5) ? 513 : 512, 640, H, L);
        end
        runVecs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
